// File: rtl/result_display_pkg.sv
// Shared types and constants for the result display: FSM states, segment
// patterns and the BCD-digit-to-segment lookup.
package result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_DIGITS = 5;

    // Segment order is {dp,g,f,e,d,c,b,a}; dp is never lit.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_R     = 8'h50;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h3F;
            4'd1:    s = 8'h06;
            4'd2:    s = 8'h5B;
            4'd3:    s = 8'h4F;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'h6D;
            4'd6:    s = 8'h7D;
            4'd7:    s = 8'h07;
            4'd8:    s = 8'h7F;
            4'd9:    s = 8'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/result_display_scan.sv
// Continuous 6-digit multiplex scan: divider, digit index and registered
// segment/digit-select outputs formatted from the display registers.
module result_display_scan
    import result_display_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] disp_bcd,
    input  logic        disp_neg,
    input  logic        disp_err,
    output logic [5:0]  digit_sel,
    output logic [7:0]  seg
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_MAX) begin
            div_d = '0;
            idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
        sel_d = 6'd1 << idx_d;

        // Pattern is formed for the index being entered so sel and seg move together.
        seg_d = SEG_BLANK;
        if (disp_err) begin
            case (idx_d)
                3'd2:       seg_d = SEG_E;
                3'd1, 3'd0: seg_d = SEG_R;
                default:    seg_d = SEG_BLANK;
            endcase
        end else if (idx_d == 3'(NUM_DIGITS - 1)) begin
            seg_d = (disp_neg && disp_bcd != 20'd0) ? SEG_MINUS : SEG_BLANK;
        end else begin
            for (int i = 0; i < BCD_DIGITS; i++) begin
                if (idx_d == 3'(i)) begin
                    // A digit is shown if it or any more significant digit is nonzero.
                    if (i == 0 || (disp_bcd >> (4 * i)) != 20'd0)
                        seg_d = seg_of(disp_bcd[i*4 +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= 3'd0;
            sel_q <= 6'b000001;
            seg_q <= seg_of(4'd0);
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign digit_sel = (SEG_ACTIVE_LOW != 0) ? ~sel_q : sel_q;
    assign seg       = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;

endmodule

// File: rtl/result_display.sv
// ALU result to 7-segment display: sequential double-dabble conversion into
// display registers, which feed the multiplexed scan.
module result_display
    import result_display_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic        IN_clk,
    input  logic        IN_reset,
    input  logic        IN_valid,
    input  logic [15:0] IN_result,
    input  logic        IN_neg,
    input  logic        IN_error,
    output logic        OUT_busy,
    output logic        OUT_done,
    output logic [19:0] OUT_bcd,
    output logic [5:0]  OUT_digit_sel,
    output logic [7:0]  OUT_seg,
    output logic [1:0]  OUT_dbg_state
);

    state_t      state_q, state_d;
    logic [15:0] bin_q, bin_d;
    logic [19:0] bcd_q, bcd_d, bcd_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d, err_q, err_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [19:0] disp_bcd_q, disp_bcd_d;
    logic        disp_neg_q, disp_neg_d, disp_err_q, disp_err_d;

    always_comb begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                          : bcd_q[i*4 +: 4];
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        disp_bcd_d = disp_bcd_q;
        disp_neg_d = disp_neg_q;
        disp_err_d = disp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_valid) begin
                    bin_d   = IN_result;
                    neg_d   = IN_neg;
                    err_d   = IN_error;
                    bcd_d   = 20'd0;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                // Shift the adjusted accumulator and the next binary bit in together.
                bcd_d = 20'({bcd_adj, bin_q[15]});
                bin_d = {bin_q[14:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                disp_bcd_d = bcd_q;
                disp_neg_d = neg_q;
                disp_err_d = err_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge IN_clk or posedge IN_reset) begin
        if (IN_reset) begin
            state_q    <= ST_IDLE;
            bin_q      <= 16'd0;
            bcd_q      <= 20'd0;
            cnt_q      <= 4'd0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            disp_bcd_q <= 20'd0;
            disp_neg_q <= 1'b0;
            disp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            disp_bcd_q <= disp_bcd_d;
            disp_neg_q <= disp_neg_d;
            disp_err_q <= disp_err_d;
        end
    end

    result_display_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_scan (
        .clk       (IN_clk),
        .rst       (IN_reset),
        .disp_bcd  (disp_bcd_q),
        .disp_neg  (disp_neg_q),
        .disp_err  (disp_err_q),
        .digit_sel (OUT_digit_sel),
        .seg       (OUT_seg)
    );

    assign OUT_busy      = busy_q;
    assign OUT_done      = done_q;
    assign OUT_bcd       = disp_bcd_q;
    assign OUT_dbg_state = state_q;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: conversion latency, BCD value and the
// six scanned display positions for each case, plus mid-conversion reset.
module tb_result_display;

    localparam int SD = 4;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [15:0] result;
    logic        neg;
    logic        err;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    result_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(0)) dut (
        .IN_clk        (clk),
        .IN_reset      (rst),
        .IN_valid      (valid),
        .IN_result     (result),
        .IN_neg        (neg),
        .IN_error      (err),
        .OUT_busy      (busy),
        .OUT_done      (done),
        .OUT_bcd       (bcd),
        .OUT_digit_sel (sel),
        .OUT_seg       (seg),
        .OUT_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one valid strobe, then follow the conversion until OUT_done.
    task automatic run_conv(input string tag, input logic [15:0] v, input logic n,
                            input logic e, input logic [19:0] exp_bcd);
        int nb;
        int to;
        valid  = 1'b1;
        result = v;
        neg    = n;
        err    = e;
        @(negedge clk);
        valid = 1'b0;
        nb = 0;
        to = 0;
        while (!done && to < 40) begin
            if (busy) nb++;
            @(negedge clk);
            to++;
        end
        chk({tag, "_busy_cycles"}, nb, 17);
        chk({tag, "_done_seen"}, done, 1'b1);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        @(negedge clk);
        chk({tag, "_done_once"}, done, 1'b0);
    endtask

    // Walk one full scan starting at position 0 and compare every slot.
    task automatic check_display(input string tag, input logic [7:0] p5, input logic [7:0] p4,
                                 input logic [7:0] p3, input logic [7:0] p2,
                                 input logic [7:0] p1, input logic [7:0] p0);
        logic [7:0] exp_p [6];
        int to;
        exp_p[0] = p0; exp_p[1] = p1; exp_p[2] = p2;
        exp_p[3] = p3; exp_p[4] = p4; exp_p[5] = p5;
        repeat (2) @(negedge clk);
        to = 0;
        while (sel !== 6'b000001 && to < 40) begin
            @(negedge clk);
            to++;
        end
        chk({tag, "_scan_sync"}, sel, 6'b000001);
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("%s_sel%0d", tag, p), sel, 6'd1 << p);
            chk($sformatf("%s_seg%0d", tag, p), seg, exp_p[p]);
            repeat (SD) @(negedge clk);
        end
    endtask

    initial begin
        int dones;
        rst    = 1'b1;
        valid  = 1'b0;
        result = 16'd0;
        neg    = 1'b0;
        err    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bcd", bcd, 20'h0);
        chk("rst_sel", sel, 6'b000001);
        chk("rst_seg", seg, 8'h3F);
        chk("rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        run_conv("v12345", 16'd12345, 1'b0, 1'b0, 20'h12345);
        check_display("d12345", 8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D);

        run_conv("negzero", 16'd0, 1'b1, 1'b0, 20'h00000);
        check_display("dnegzero", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F);

        run_conv("v65535", 16'd65535, 1'b0, 1'b0, 20'h65535);
        check_display("d65535", 8'h00, 8'h7D, 8'h6D, 8'h6D, 8'h4F, 8'h6D);

        run_conv("neg42", 16'd42, 1'b1, 1'b0, 20'h00042);
        check_display("dneg42", 8'h40, 8'h00, 8'h00, 8'h00, 8'h66, 8'h5B);

        run_conv("err", 16'd1234, 1'b0, 1'b1, 20'h01234);
        check_display("derr", 8'h00, 8'h00, 8'h00, 8'h79, 8'h50, 8'h50);

        run_conv("v7", 16'd7, 1'b0, 1'b0, 20'h00007);
        check_display("d7", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07);

        // A second strobe during conversion must be dropped.
        valid  = 1'b1;
        result = 16'd1;
        @(negedge clk);
        valid = 1'b0;
        dones = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) dones++;
            if (c == 5) begin
                valid  = 1'b1;
                result = 16'd999;
            end else begin
                valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_dones", dones, 1);
        chk("ign_bcd", bcd, 20'h00001);
        check_display("dign", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06);

        // Reset in the middle of a conversion.
        valid  = 1'b1;
        result = 16'd4321;
        @(negedge clk);
        valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy", busy, 1'b0);
        chk("mid_bcd", bcd, 20'h0);
        chk("mid_sel", sel, 6'b000001);
        chk("mid_seg", seg, 8'h3F);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (c <= 3) chk($sformatf("mid_rot%0d", c), sel, 6'b000001);
            if (c == 4) chk("mid_rot4", sel, 6'b000010);
        end
        chk("mid_no_done", dones, 0);
        chk("mid_state", dbg_state, 2'd0);
        check_display("dmid", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
